// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot frame writer: default geometry,
// bus widths, the writer state encoding and a counter-width helper.
package mandelbrot_pkg;

  // Default frame geometry and bus widths.
  localparam int HRES_DEF = 640;
  localparam int VRES_DEF = 480;
  localparam int MAW_DEF  = 19;
  localparam int MDW_DEF  = 8;
  localparam int IW_DEF   = 10;

  // Writer control states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/mandelbrot_color_map.sv
// Combinational iteration-count to palette-index mapping.
// In-set pixels are black (0). Out-of-set pixels map to their iteration count,
// clamped into 1..2^MDW-1 so they can never be confused with in-set black.
module mandelbrot_color_map
  import mandelbrot_pkg::*;
#(
  parameter int IW  = IW_DEF,
  parameter int MDW = MDW_DEF
) (
  input  logic [IW-1:0]  iter,
  input  logic           inset,
  output logic [MDW-1:0] color
);

  // Saturation can only happen when the count is wider than the colour.
  localparam bit SAT_POSSIBLE = (IW > MDW);
  localparam int CMAX         = (1 << MDW) - 1;

  // Select black, the lower clamp, the upper clamp or the raw count.
  always_comb begin
    color = {MDW{1'b0}};
    if (inset) begin
      color = {MDW{1'b0}};
    end else if (iter == {IW{1'b0}}) begin
      color = MDW'(1'b1);
    end else if (SAT_POSSIBLE && (iter > IW'(CMAX))) begin
      color = {MDW{1'b1}};
    end else begin
      color = MDW'(iter);
    end
  end

endmodule

// File: rtl/mandelbrot_vram_writer.sv
// Mandelbrot frame writer: takes the raster-ordered pixel result stream and
// writes one palette index per pixel into video memory at y*HRES + x.
// The address is a running counter (no multiplier); x/y only detect line
// wrap and the final pixel. All state advances only when clk_en is high, and
// the memory port is expected to use clk_en as its write enable, so a held
// vram_we never produces a duplicate write.
//
// Optional feature macro: MANDELBROT_WRITER_INSET_CNT_EN
//   defined   : inset_cnt reports the number of in-set pixels of the last
//               completed frame (aborted frames leave it unchanged).
//   undefined : inset_cnt is tied to zero.
module mandelbrot_vram_writer
  import mandelbrot_pkg::*;
#(
  parameter int HRES = HRES_DEF,
  parameter int VRES = VRES_DEF,
  parameter int MAW  = MAW_DEF,
  parameter int MDW  = MDW_DEF,
  parameter int IW   = IW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clk_en,
  input  logic           start,
  input  logic           abort,
  input  logic           pix_vld,
  output logic           pix_rdy,
  input  logic [IW-1:0]  pix_iter,
  input  logic           pix_inset,
  output logic           vram_we,
  output logic [MAW-1:0] vram_adr,
  output logic [MDW-1:0] vram_dat,
  output logic           busy,
  output logic           frame_done,
  output logic [MAW-1:0] inset_cnt
);

  localparam int XW = cnt_width(HRES);
  localparam int YW = cnt_width(VRES);

  localparam logic [XW-1:0] X_LAST = XW'(HRES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VRES - 1);

  state_t         state_r;
  state_t         state_nxt_s;
  logic           clear_s;
  logic           run_s;
  logic           accept_s;
  logic           write_s;
  logic           last_s;
  logic [XW-1:0]  x_r;
  logic [YW-1:0]  y_r;
  logic [MAW-1:0] adr_r;
  logic [MDW-1:0] color_s;
  logic           vram_we_r;
  logic [MAW-1:0] vram_adr_r;
  logic [MDW-1:0] vram_dat_r;
  logic           frame_done_r;

  assign run_s    = (state_r == RUN);
  assign pix_rdy  = run_s;
  assign busy     = run_s;
  assign accept_s = pix_vld & run_s & clk_en;
  // Abort wins over a simultaneous acceptance: the pixel is dropped.
  assign write_s  = accept_s & ~abort;
  assign last_s   = (x_r == X_LAST) && (y_r == Y_LAST);

  mandelbrot_color_map #(
    .IW  (IW),
    .MDW (MDW)
  ) u_color_map (
    .iter  (pix_iter),
    .inset (pix_inset),
    .color (color_s)
  );

  // Next-state decode; counters are cleared on every frame boundary.
  always_comb begin
    state_nxt_s = state_r;
    clear_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt_s = IDLE;
          clear_s     = 1'b1;
        end else if (write_s && last_s) begin
          state_nxt_s = IDLE;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        clear_s     = 1'b1;
      end
    endcase
  end

  // State register, advancing only on enabled cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else if (clk_en) begin
      state_r <= state_nxt_s;
    end
  end

  // Raster position and linear address counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r   <= {XW{1'b0}};
      y_r   <= {YW{1'b0}};
      adr_r <= {MAW{1'b0}};
    end else if (clk_en) begin
      if (clear_s) begin
        x_r   <= {XW{1'b0}};
        y_r   <= {YW{1'b0}};
        adr_r <= {MAW{1'b0}};
      end else if (write_s) begin
        adr_r <= adr_r + MAW'(1'b1);
        if (x_r == X_LAST) begin
          x_r <= {XW{1'b0}};
          y_r <= y_r + YW'(1'b1);
        end else begin
          x_r <= x_r + XW'(1'b1);
        end
      end
    end
  end

  // Memory write port and completion pulse, one enabled cycle after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_we_r    <= 1'b0;
      vram_adr_r   <= {MAW{1'b0}};
      vram_dat_r   <= {MDW{1'b0}};
      frame_done_r <= 1'b0;
    end else if (clk_en) begin
      vram_we_r    <= write_s;
      frame_done_r <= write_s & last_s;
      if (write_s) begin
        vram_adr_r <= adr_r;
        vram_dat_r <= color_s;
      end
    end
  end

  assign vram_we    = vram_we_r;
  assign vram_adr   = vram_adr_r;
  assign vram_dat   = vram_dat_r;
  assign frame_done = frame_done_r;

`ifdef MANDELBROT_WRITER_INSET_CNT_EN
  logic [MAW-1:0] inset_acc_r;
  logic [MAW-1:0] inset_cnt_r;
  logic [MAW-1:0] inset_inc_s;

  assign inset_inc_s = {{(MAW-1){1'b0}}, (write_s & pix_inset)};

  // Running in-set tally; published only when a frame completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inset_acc_r <= {MAW{1'b0}};
      inset_cnt_r <= {MAW{1'b0}};
    end else if (clk_en) begin
      if (write_s && last_s) begin
        inset_cnt_r <= inset_acc_r + inset_inc_s;
      end
      if (clear_s) begin
        inset_acc_r <= {MAW{1'b0}};
      end else begin
        inset_acc_r <= inset_acc_r + inset_inc_s;
      end
    end
  end

  assign inset_cnt = inset_cnt_r;
`else
  assign inset_cnt = {MAW{1'b0}};
`endif

endmodule

// File: doc/mandelbrot_vram_writer.md
MANDELBROT_VRAM_WRITER -- requirements
Module: mandelbrot_vram_writer

Interface
REQ-001 SHALL have parameter HRES, default 640, horizontal resolution in pixels.
REQ-002 SHALL have parameter VRES, default 480, vertical resolution in lines.
REQ-003 SHALL have parameter MAW, default 19, video memory address width.
REQ-004 SHALL have parameter MDW, default 8, video memory data width.
REQ-005 SHALL have parameter IW, default 10, iteration count width.
REQ-006 SHALL have ports: clk  in  1  system clock; single clock domain.
REQ-007 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports: clk_en  in  1  clock enable; all state updates qualified by it.
REQ-009 SHALL have ports: start  in  1  begin frame, one-cycle pulse; abort  in  1  cancel frame.
REQ-010 SHALL have ports: pix_vld  in  1, pix_rdy  out  1, pix_iter  in  IW, pix_inset  in  1  (pixel result stream, raster order).
REQ-011 SHALL have ports: vram_we  out  1, vram_adr  out  MAW, vram_dat  out  MDW  (video memory write port).
REQ-012 SHALL have ports: busy  out  1  frame in progress; frame_done  out  1  one-cycle completion pulse; inset_cnt  out  MAW  in-set pixels in last completed frame.

Function
REQ-013 SHALL implement FSM IDLE -> RUN on start; RUN -> IDLE on abort or on accepting the last pixel.
REQ-014 SHALL drive pix_rdy=1 only in RUN; busy=1 exactly in RUN.
REQ-015 SHALL accept a pixel when pix_vld & pix_rdy & clk_en.
REQ-016 SHALL register each accepted pixel into vram_we=1, vram_adr, vram_dat on the next enabled edge; latency 1 cycle; vram_we=0 on enabled cycles with no acceptance.
REQ-017 SHALL map colour: pix_inset=1 -> 0; otherwise min(max(pix_iter,1), 2^MDW-1), so out-of-set is never 0.
REQ-018 SHALL generate vram_adr = y*HRES + x by linear counter; x wraps at HRES-1 to 0 and increments y; no multiplier.
REQ-019 SHALL treat x=HRES-1, y=VRES-1 as last pixel: write it, pulse frame_done for one enabled cycle with the write, return to IDLE.
REQ-020 SHALL ignore start while in RUN; SHALL ignore abort in IDLE.
REQ-021 SHALL give abort priority over a simultaneous acceptance: pixel dropped, no write, no frame_done, counters cleared.
REQ-022 SHALL clear x, y and address counters on every start.
REQ-023 SHALL hold all registers, including vram_we, while clk_en=0; the memory write port uses clk_en as its enable, so no duplicate writes occur.

Reset
REQ-024 SHALL on rst force IDLE, pix_rdy=0, busy=0, vram_we=0, vram_adr=0, vram_dat=0, frame_done=0, inset_cnt=0, counters 0.
REQ-025 SHALL on rst mid-frame abandon the frame; the next frame requires a fresh start.

Configuration
REQ-026 SHALL, with MANDELBROT_WRITER_INSET_CNT_EN defined, count accepted pixels with pix_inset=1 and load inset_cnt with the total when frame_done pulses; aborted frames leave inset_cnt unchanged.
REQ-027 SHALL, without MANDELBROT_WRITER_INSET_CNT_EN, keep the inset_cnt port and tie it to 0; no counter logic.

Structure
REQ-028 SHALL take HRES/VRES defaults, MAW, MDW, IW and the state enum (IDLE, RUN) from package mandelbrot_pkg.
REQ-029 SHALL place the colour mapping in sub-module mandelbrot_color_map (combinational, IW in, MDW out).

Verification (HRES=4, VRES=3, IW=10, MDW=8 unless noted)
REQ-030 SHALL cover: start, 12 pixels with pix_vld=1, iter=5 -> writes at adr 0..11, dat=5, frame_done on the adr 11 write, busy falls the next cycle.
REQ-031 SHALL cover: iter=0 -> dat=1; iter=300 -> dat=255; pix_inset=1 with iter=40 -> dat=0.
REQ-032 SHALL cover: abort with pix_vld at pixel 6 -> no write for pixel 6, no frame_done; the next start writes from adr 0.
REQ-033 SHALL cover: clk_en toggling 1/0 during frame -> exactly 12 writes, no address repeated or skipped.
REQ-034 SHALL cover: macro defined, 5 of 12 pixels in-set -> inset_cnt=5 at frame_done; macro undefined -> inset_cnt=0.
REQ-035 SHALL cover: rst asserted at pixel 7 -> all outputs 0 immediately, IDLE, pix_rdy=0 until the next start.
